// File: rtl/bus_pkg.sv
// Shared types and defaults for the split-capable bus arbiter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

    localparam int DEFAULT_NUM_MASTERS = 4;
    localparam int DEFAULT_NUM_SLAVES  = 3;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: resumed masters first, then fixed priority
// or round-robin starting just after the last granted master.
module arb_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int MID_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] eligible,
    input  logic [NUM_MASTERS-1:0] resumable,
    input  logic [MID_W-1:0]       rr_ptr,
    input  logic                   rr_mode,
    output logic [NUM_MASTERS-1:0] win_onehot,
    output logic [MID_W-1:0]       win_id,
    output logic                   win_valid
);

    logic [NUM_MASTERS-1:0] cand;
    logic                   use_rr;
    logic [MID_W-1:0]       idx;

    always_comb begin
        cand   = eligible & resumable;
        use_rr = 1'b0;
        // Resumed masters always take the lowest index; rotation only applies otherwise.
        if (cand == '0) begin
            cand   = eligible;
            use_rr = rr_mode;
        end
        win_valid = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (use_rr)
                idx = MID_W'((int'(rr_ptr) + 1 + k) % NUM_MASTERS);
            else
                idx = MID_W'(k);
            if (!win_valid && cand[idx]) begin
                win_valid = 1'b1;
                win_id    = idx;
            end
        end
        win_onehot = win_valid ? (NUM_MASTERS'(1) << win_id) : '0;
    end

endmodule

// File: rtl/bus_arbiter_split.sv
// N-master bus arbiter with split (park/resume) support and selectable
// fixed-priority or round-robin arbitration.
module bus_arbiter_split
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
    parameter int NUM_SLAVES  = DEFAULT_NUM_SLAVES,
    parameter int SLAVE_LEN   = 2,
    parameter int MID_W       = $clog2(NUM_MASTERS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rr_mode,
    input  logic [NUM_MASTERS-1:0]         m_request,
    input  logic [NUM_MASTERS*SLAVE_LEN-1:0] m_slave_sel,
    input  logic                           trans_done,
    input  logic [NUM_SLAVES-1:0]          s_split_en,
    output logic [NUM_MASTERS-1:0]         m_grant,
    output logic [NUM_MASTERS-1:0]         m_split,
    output logic [MID_W-1:0]               grant_id,
    output logic [SLAVE_LEN-1:0]           sel_slave,
    output logic                           arbiter_busy,
    output logic                           bus_busy
);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] m_grant_q, m_grant_d;
    logic [NUM_MASTERS-1:0] m_split_q, m_split_d;
    logic [NUM_MASTERS-1:0] resumable_q, resumable_d;
    logic [MID_W-1:0]       grant_id_q, grant_id_d;
    logic [MID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [SLAVE_LEN-1:0]   sel_slave_q, sel_slave_d;
    logic [SLAVE_LEN-1:0]   parked_q [NUM_MASTERS];
    logic [SLAVE_LEN-1:0]   parked_d [NUM_MASTERS];
    logic [NUM_SLAVES-1:0]  split_prev_q;
    logic                   arbiter_busy_q, arbiter_busy_d;
    logic                   bus_busy_q, bus_busy_d;

    logic [SLAVE_LEN-1:0]   sel_arr [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] win_onehot;
    logic [MID_W-1:0]       win_id;
    logic                   win_valid;
    logic                   owner_split_rise;

    function automatic logic slave_bit(input logic [NUM_SLAVES-1:0] v,
                                       input logic [SLAVE_LEN-1:0] sidx);
        logic r;
        r = 1'b0;
        for (int s = 0; s < NUM_SLAVES; s++)
            if (SLAVE_LEN'(s) == sidx) r = v[s];
        return r;
    endfunction

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            sel_arr[i]  = m_slave_sel[i*SLAVE_LEN +: SLAVE_LEN];
            eligible[i] = m_request[i] && !m_split_q[i] && (int'(sel_arr[i]) < NUM_SLAVES);
        end
    end

    arb_pick #(
        .NUM_MASTERS(NUM_MASTERS),
        .MID_W      (MID_W)
    ) u_pick (
        .eligible  (eligible),
        .resumable (resumable_q),
        .rr_ptr    (rr_ptr_q),
        .rr_mode   (rr_mode),
        .win_onehot(win_onehot),
        .win_id    (win_id),
        .win_valid (win_valid)
    );

    assign owner_split_rise = slave_bit(s_split_en, sel_slave_q) &&
                              !slave_bit(split_prev_q, sel_slave_q);

    always_comb begin
        state_d     = state_q;
        m_grant_d   = m_grant_q;
        m_split_d   = m_split_q;
        resumable_d = resumable_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        sel_slave_d = sel_slave_q;
        parked_d    = parked_q;

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d     = GRANT;
                    m_grant_d   = win_onehot;
                    grant_id_d  = win_id;
                    sel_slave_d = sel_arr[win_id];
                    rr_ptr_d    = win_id;
                    resumable_d = '0;
                end
            end
            GRANT: state_d = BUSY;
            BUSY: begin
                // Completion outranks a split arriving in the same cycle.
                if (trans_done) begin
                    state_d   = IDLE;
                    m_grant_d = '0;
                end else if (owner_split_rise) begin
                    state_d               = IDLE;
                    m_grant_d             = '0;
                    m_split_d[grant_id_q] = 1'b1;
                    parked_d[grant_id_q]  = sel_slave_q;
                end else if (!m_request[grant_id_q]) begin
                    state_d   = IDLE;
                    m_grant_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                m_grant_d = '0;
            end
        endcase

        // Unpark when the parked slave drops its split; a still-requesting master gets priority once.
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (m_split_q[i] && !slave_bit(s_split_en, parked_q[i])) begin
                m_split_d[i] = 1'b0;
                if (m_request[i]) resumable_d[i] = 1'b1;
            end
        end

        arbiter_busy_d = (state_d != IDLE);
        bus_busy_d     = (state_d == BUSY);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            m_grant_q      <= '0;
            m_split_q      <= '0;
            resumable_q    <= '0;
            grant_id_q     <= '0;
            rr_ptr_q       <= MID_W'(NUM_MASTERS - 1);
            sel_slave_q    <= '0;
            parked_q       <= '{default: '0};
            split_prev_q   <= '0;
            arbiter_busy_q <= 1'b0;
            bus_busy_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            m_grant_q      <= m_grant_d;
            m_split_q      <= m_split_d;
            resumable_q    <= resumable_d;
            grant_id_q     <= grant_id_d;
            rr_ptr_q       <= rr_ptr_d;
            sel_slave_q    <= sel_slave_d;
            parked_q       <= parked_d;
            split_prev_q   <= s_split_en;
            arbiter_busy_q <= arbiter_busy_d;
            bus_busy_q     <= bus_busy_d;
        end
    end

    assign m_grant      = m_grant_q;
    assign m_split      = m_split_q;
    assign grant_id     = grant_id_q;
    assign sel_slave    = sel_slave_q;
    assign arbiter_busy = arbiter_busy_q;
    assign bus_busy     = bus_busy_q;

endmodule

// File: tb/tb_bus_arbiter_split.sv
// Directed scoreboard bench for bus_arbiter_split: expected grants are queued
// by the stimulus and popped by a monitor as each new grant appears.
module tb_bus_arbiter_split;

    localparam int NM = 4;
    localparam int NS = 3;
    localparam int SL = 2;
    localparam int MW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            rr_mode = 1'b0;
    logic [NM-1:0]   m_request = '0;
    logic [NM*SL-1:0] m_slave_sel = '0;
    logic            trans_done = 1'b0;
    logic [NS-1:0]   s_split_en = '0;
    logic [NM-1:0]   m_grant;
    logic [NM-1:0]   m_split;
    logic [MW-1:0]   grant_id;
    logic [SL-1:0]   sel_slave;
    logic            arbiter_busy;
    logic            bus_busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct packed {
        logic [NM-1:0] grant;
        logic [SL-1:0] sel;
    } exp_t;

    exp_t          exp_q[$];
    logic [NM-1:0] prev_grant = '0;

    always #5 clk = ~clk;

    bus_arbiter_split #(
        .NUM_MASTERS(NM),
        .NUM_SLAVES (NS),
        .SLAVE_LEN  (SL),
        .MID_W      (MW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rr_mode     (rr_mode),
        .m_request   (m_request),
        .m_slave_sel (m_slave_sel),
        .trans_done  (trans_done),
        .s_split_en  (s_split_en),
        .m_grant     (m_grant),
        .m_split     (m_split),
        .grant_id    (grant_id),
        .sel_slave   (sel_slave),
        .arbiter_busy(arbiter_busy),
        .bus_busy    (bus_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NM-1:0] req, input logic [NM*SL-1:0] sel);
        m_request   = req;
        m_slave_sel = sel;
    endtask

    function automatic logic [NM*SL-1:0] packSel(input logic [SL-1:0] s0, input logic [SL-1:0] s1,
                                                 input logic [SL-1:0] s2, input logic [SL-1:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic expectGrant(input int id, input logic [SL-1:0] sel);
        exp_t e;
        e.grant = NM'(1) << id;
        e.sel   = sel;
        exp_q.push_back(e);
    endtask

    task automatic applyReset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic waitGrant(input string name);
        for (int i = 0; i < 20 && m_grant == '0; i++) tick();
        checkOutput(name, 32'(m_grant != '0), 32'd1);
    endtask

    task automatic waitIdle(input string name);
        for (int i = 0; i < 20 && arbiter_busy; i++) tick();
        checkOutput(name, 32'(arbiter_busy), 32'd0);
    endtask

    // Scoreboard monitor: every new nonzero grant must match the queue head.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && m_grant !== '0 && m_grant !== prev_grant) begin
            n_compared++;
            if (exp_q.size() == 0) begin
                n_mismatched++;
                $display("[TB] FAIL unexpected_grant: got grant %b sel %0d, expected no grant",
                         m_grant, sel_slave);
            end else begin
                e = exp_q.pop_front();
                if (m_grant !== e.grant || sel_slave !== e.sel) begin
                    n_mismatched++;
                    $display("[TB] FAIL grant_order: got grant %b sel %0d, expected grant %b sel %0d",
                             m_grant, sel_slave, e.grant, e.sel);
                end
            end
        end
        prev_grant = m_grant;
    end

    initial begin
        // Reset state
        applyReset();
        checkOutput("rst_grant", 32'(m_grant), 32'd0);
        checkOutput("rst_split", 32'(m_split), 32'd0);
        checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
        checkOutput("rst_sel_slave", 32'(sel_slave), 32'd0);
        checkOutput("rst_arb_busy", 32'(arbiter_busy), 32'd0);
        checkOutput("rst_bus_busy", 32'(bus_busy), 32'd0);

        // Fixed priority with requests 1010
        rr_mode = 1'b0;
        applyStimulus(4'b1010, packSel(2'd0, 2'd1, 2'd0, 2'd2));
        expectGrant(1, 2'd1);
        expectGrant(3, 2'd2);
        tick();
        checkOutput("fp_grant", 32'(m_grant), 32'b0010);
        checkOutput("fp_arb_busy", 32'(arbiter_busy), 32'd1);
        checkOutput("fp_bus_busy_setup", 32'(bus_busy), 32'd0);
        tick();
        checkOutput("fp_bus_busy", 32'(bus_busy), 32'd1);
        tick();
        tick();
        trans_done = 1'b1;
        m_request  = 4'b1000;
        tick();
        trans_done = 1'b0;
        checkOutput("done_grant_low", 32'(m_grant), 32'd0);
        checkOutput("done_arb_low", 32'(arbiter_busy), 32'd0);
        checkOutput("done_bus_low", 32'(bus_busy), 32'd0);
        tick();
        checkOutput("fp_second_grant", 32'(m_grant), 32'b1000);
        checkOutput("fp_second_sel", 32'(sel_slave), 32'd2);
        m_request = '0;
        waitIdle("fp_idle");

        // Round-robin: all request, order 0,1,2,3,0
        applyReset();
        rr_mode = 1'b1;
        applyStimulus(4'b1111, packSel(2'd0, 2'd0, 2'd0, 2'd0));
        for (int r = 0; r < 5; r++) expectGrant(r % NM, 2'd0);
        for (int r = 0; r < 5; r++) begin
            waitGrant("rr_wait");
            tick();
            tick();
            trans_done = 1'b1;
            if (r == 4) m_request = '0;
            tick();
            trans_done = 1'b0;
        end
        waitIdle("rr_idle");

        // Split park and resume priority
        rr_mode = 1'b0;
        applyStimulus(4'b0010, packSel(2'd0, 2'd2, 2'd0, 2'd0));
        expectGrant(1, 2'd2);
        waitGrant("split_first");
        tick();
        s_split_en = 3'b100;
        m_request  = 4'b1010;
        expectGrant(3, 2'd0);
        tick();
        checkOutput("split_parked", 32'(m_split), 32'b0010);
        checkOutput("split_grant_low", 32'(m_grant), 32'd0);
        waitGrant("split_other");
        tick();
        trans_done = 1'b1;
        m_request  = 4'b0010;
        tick();
        trans_done = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("parked_blocked", 32'(m_grant), 32'd0);
        checkOutput("parked_held", 32'(m_split), 32'b0010);
        s_split_en = 3'b000;
        tick();
        checkOutput("split_release", 32'(m_split), 32'd0);
        m_request = 4'b0011;
        expectGrant(1, 2'd2);
        expectGrant(0, 2'd0);
        waitGrant("resume_wait");
        tick();
        trans_done = 1'b1;
        m_request  = 4'b0001;
        tick();
        trans_done = 1'b0;
        waitGrant("after_resume");
        m_request = '0;
        waitIdle("split_idle");

        // Completion and split rise together
        applyStimulus(4'b0100, packSel(2'd0, 2'd0, 2'd1, 2'd0));
        expectGrant(2, 2'd1);
        waitGrant("dual_wait");
        tick();
        s_split_en = 3'b010;
        trans_done = 1'b1;
        m_request  = '0;
        tick();
        checkOutput("done_beats_split", 32'(m_split), 32'd0);
        checkOutput("dual_grant_low", 32'(m_grant), 32'd0);
        trans_done = 1'b0;
        s_split_en = 3'b000;
        tick();

        // Out-of-range slave select
        applyStimulus(4'b0100, packSel(2'd0, 2'd0, 2'd3, 2'd0));
        tick();
        tick();
        tick();
        tick();
        checkOutput("oor_no_grant", 32'(m_grant), 32'd0);
        checkOutput("oor_idle", 32'(arbiter_busy), 32'd0);
        expectGrant(0, 2'd0);
        applyStimulus(4'b0101, packSel(2'd0, 2'd0, 2'd3, 2'd0));
        waitGrant("oor_other");
        checkOutput("oor_other_id", 32'(grant_id), 32'd0);
        m_request = 4'b0100;
        waitIdle("oor_abort");
        tick();
        tick();
        checkOutput("oor_never", 32'(m_grant), 32'd0);
        m_request = '0;

        // Reset while busy with a parked master
        applyStimulus(4'b0010, packSel(2'd0, 2'd2, 2'd0, 2'd0));
        expectGrant(1, 2'd2);
        waitGrant("rstp_first");
        tick();
        s_split_en = 3'b100;
        m_request  = 4'b1010;
        expectGrant(3, 2'd0);
        tick();
        checkOutput("rstp_parked", 32'(m_split), 32'b0010);
        waitGrant("rstp_other");
        tick();
        rst = 1'b0;
        tick();
        checkOutput("rstp_grant", 32'(m_grant), 32'd0);
        checkOutput("rstp_split", 32'(m_split), 32'd0);
        checkOutput("rstp_grant_id", 32'(grant_id), 32'd0);
        checkOutput("rstp_sel", 32'(sel_slave), 32'd0);
        checkOutput("rstp_arb_busy", 32'(arbiter_busy), 32'd0);
        checkOutput("rstp_bus_busy", 32'(bus_busy), 32'd0);
        rst       = 1'b1;
        m_request = 4'b0010;
        expectGrant(1, 2'd2);
        waitGrant("rstp_regrant");
        checkOutput("rstp_not_parked", 32'(m_split), 32'd0);
        m_request  = '0;
        s_split_en = 3'b000;
        waitIdle("rstp_idle");

        tick();
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
